// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU operand sequencer.
package alu_seq_pkg;

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam logic [1:0] KIND_READ = 2'b10;

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_XOR = 3'b100;
  localparam logic [2:0] MODE_NOT = 3'b101;
  localparam logic [2:0] MODE_SLT = 3'b110;
  localparam logic [2:0] MODE_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Only the adder modes produce meaningful zero/overflow/carry from the ALU.
  function automatic logic uses_adder_flags(input logic [2:0] mode);
    return (mode == MODE_ADD) || (mode == MODE_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x WIDTH register file: two combinational read ports, one synchronous write port.
module alu_seq_regfile #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [RW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == RW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven operand sequencer: feeds an external combinational ALU one command at a time
// and returns each result over a valid/ready response channel.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_mode,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [RW-1:0]    cmd_rs1,
  input  logic [RW-1:0]    cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry
);

  state_e           state_reg, state_next;
  logic [2:0]       mode_reg;
  logic [RW-1:0]    rd_reg, rs1_reg, rs2_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [2:0]       flags_reg;

  logic             accept, in_exec;
  logic             rf_we;
  logic [RW-1:0]    rf_waddr, rf_raddr1;
  logic [WIDTH-1:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic [2:0]       exec_flags;

  assign accept  = cmd_valid && (state_reg == ST_IDLE);
  assign in_exec = (state_reg == ST_EXEC);

  // Port 1 serves READ at accept time and operand A during EXEC.
  assign rf_raddr1 = in_exec ? rs1_reg : cmd_rs1;
  assign rf_we     = in_exec || (accept && (cmd_kind == KIND_LOAD));
  assign rf_waddr  = in_exec ? rd_reg : cmd_rd;
  assign rf_wdata  = in_exec ? alu_result : cmd_imm;

  alu_seq_regfile #(
    .WIDTH(WIDTH),
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr1(rf_raddr1),
    .rdata1(rf_rdata1),
    .raddr2(rs2_reg),
    .rdata2(rf_rdata2)
  );

  assign alu_a     = in_exec ? rf_rdata1 : '0;
  assign alu_b     = in_exec ? rf_rdata2 : '0;
  assign alu_mode  = in_exec ? mode_reg : '0;
  assign cmd_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_flags = flags_reg;

  always_comb begin
    exec_flags = '0;
    if (uses_adder_flags(mode_reg)) begin
      exec_flags[FLAG_Z] = alu_zero;
      exec_flags[FLAG_V] = alu_overflow;
      exec_flags[FLAG_C] = alu_carry;
    end else begin
      exec_flags[FLAG_Z] = (alu_result == '0);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = (cmd_kind == KIND_ALU) ? ST_EXEC : ST_RESP;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= '0;
      rd_reg       <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rsp_data_reg <= '0;
      flags_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mode_reg <= cmd_mode;
        rd_reg   <= cmd_rd;
        rs1_reg  <= cmd_rs1;
        rs2_reg  <= cmd_rs2;
        // Reserved kind 11 behaves as READ.
        if (cmd_kind == KIND_LOAD) begin
          rsp_data_reg <= cmd_imm;
        end else if (cmd_kind != KIND_ALU) begin
          rsp_data_reg <= rf_rdata1;
        end
      end
      if (in_exec) begin
        rsp_data_reg <= alu_result;
        flags_reg    <= exec_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the far side, directed table, corner sequences, random traffic.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_kind = '0;
  logic [2:0] cmd_mode = '0;
  logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [7:0] cmd_imm = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [2:0] rsp_flags;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_mode;
  logic [7:0] alu_result;
  logic       alu_zero, alu_overflow, alu_carry;

  int checks = 0;
  int failures = 0;

  logic [7:0] rf_model [4];
  logic [2:0] flags_model;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_mode(cmd_mode),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry)
  );

  // Stand-in for the external ALU; logic modes drive deliberately bogus flags.
  logic [8:0] sum9;
  always_comb begin
    sum9         = '0;
    alu_result   = '0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_mode)
      3'b000: begin
        sum9         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum9[7:0];
        alu_carry    = sum9[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
        alu_zero     = (sum9[7:0] == 8'h00);
      end
      3'b001: begin
        sum9         = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        alu_result   = sum9[7:0];
        alu_carry    = sum9[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (sum9[7] != alu_a[7]);
        alu_zero     = (sum9[7:0] == 8'h00);
      end
      default: begin
        case (alu_mode)
          3'b010:  alu_result = alu_a & alu_b;
          3'b011:  alu_result = alu_a | alu_b;
          3'b100:  alu_result = alu_a ^ alu_b;
          3'b101:  alu_result = ~alu_a;
          3'b110:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
          default: alu_result = (alu_a == alu_b) ? 8'h01 : 8'h00;
        endcase
        alu_zero     = (alu_result != 8'h00);
        alu_overflow = 1'b1;
        alu_carry    = 1'b1;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sx8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference: what an ALU command should yield, from plain integer arithmetic.
  function automatic void model_alu(input logic [2:0] m, input int a, input int b,
                                    output int res, output logic [2:0] fl);
    int s;
    s = 0;
    case (m)
      3'd0: begin
        res = (a + b) & 255;
        s   = sx8(a) + sx8(b);
        fl  = {res == 0, (s > 127) || (s < -128), (a + b) > 255};
      end
      3'd1: begin
        res = (a - b) & 255;
        s   = sx8(a) - sx8(b);
        fl  = {res == 0, (s > 127) || (s < -128), a >= b};
      end
      default: begin
        case (m)
          3'd2:    res = a & b;
          3'd3:    res = a | b;
          3'd4:    res = a ^ b;
          3'd5:    res = (~a) & 255;
          3'd6:    res = (sx8(a) < sx8(b)) ? 1 : 0;
          default: res = (a == b) ? 1 : 0;
        endcase
        fl = {res == 0, 1'b0, 1'b0};
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_model[i] = 8'h00;
    flags_model = 3'b000;
  endtask

  // One full transaction; compares against the table value when use_tbl, otherwise the model.
  task automatic do_cmd(input logic [1:0] kind, input logic [2:0] mode, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                        input bit use_tbl, input logic [7:0] tbl_d, input logic [2:0] tbl_f,
                        input int stall, input string tag);
    int res, lat, want_lat;
    logic [2:0] fl;
    logic [7:0] exp_d;
    logic [2:0] exp_f;
    model_alu(mode, int'(rf_model[rs1]), int'(rf_model[rs2]), res, fl);
    exp_f = flags_model;
    if (kind == KIND_ALU) begin
      exp_d = 8'(res);
      exp_f = fl;
    end else if (kind == KIND_LOAD) begin
      exp_d = imm;
    end else begin
      exp_d = rf_model[rs1];
    end
    if (use_tbl) begin
      exp_d = tbl_d;
      exp_f = tbl_f;
    end
    @(negedge clk);
    check({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_kind = kind; cmd_mode = mode; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (kind == KIND_ALU) begin
      check({tag, " exec_a"}, 32'(alu_a), 32'(rf_model[rs1]));
      check({tag, " exec_b"}, 32'(alu_b), 32'(rf_model[rs2]));
      check({tag, " exec_mode"}, 32'(alu_mode), 32'(mode));
    end else begin
      check({tag, " idle_alu_a"}, 32'(alu_a), 32'd0);
    end
    want_lat = (kind == KIND_ALU) ? 2 : 1;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(want_lat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
    check({tag, " rsp_flags"}, 32'(rsp_flags), 32'(exp_f));
    $display("txn %s kind=%0d mode=%0d rd=%0d rs1=%0d rs2=%0d imm=%02h -> data=%02h flags=%03b",
             tag, kind, mode, rd, rs1, rs2, imm, rsp_data, rsp_flags);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    if (kind == KIND_ALU) begin
      rf_model[rd] = 8'(res);
      flags_model  = fl;
    end else if (kind == KIND_LOAD) begin
      rf_model[rd] = imm;
    end
  endtask

  typedef struct {
    logic [1:0] kind;
    logic [2:0] mode;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] exp_d;
    logic [2:0] exp_f;
  } vec_t;

  vec_t tbl [25];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{KIND_READ, MODE_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 3'b000};
    tbl[1]  = '{KIND_READ, MODE_ADD, 2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 3'b000};
    tbl[2]  = '{KIND_READ, MODE_ADD, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00, 3'b000};
    tbl[3]  = '{KIND_READ, MODE_ADD, 2'd0, 2'd3, 2'd0, 8'h00, 8'h00, 3'b000};
    tbl[4]  = '{KIND_LOAD, MODE_ADD, 2'd1, 2'd0, 2'd0, 8'h7F, 8'h7F, 3'b000};
    tbl[5]  = '{KIND_LOAD, MODE_ADD, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 3'b000};
    tbl[6]  = '{KIND_ALU,  MODE_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h80, 3'b010};
    tbl[7]  = '{KIND_READ, MODE_ADD, 2'd0, 2'd3, 2'd0, 8'h00, 8'h80, 3'b010};
    tbl[8]  = '{KIND_ALU,  MODE_SUB, 2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 3'b101};
    tbl[9]  = '{KIND_READ, MODE_ADD, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00, 3'b101};
    tbl[10] = '{KIND_LOAD, MODE_ADD, 2'd1, 2'd0, 2'd0, 8'h80, 8'h80, 3'b101};
    tbl[11] = '{KIND_LOAD, MODE_ADD, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 3'b101};
    tbl[12] = '{KIND_ALU,  MODE_SLT, 2'd3, 2'd1, 2'd2, 8'h00, 8'h01, 3'b000};
    tbl[13] = '{KIND_LOAD, MODE_ADD, 2'd1, 2'd0, 2'd0, 8'h55, 8'h55, 3'b000};
    tbl[14] = '{KIND_LOAD, MODE_ADD, 2'd2, 2'd0, 2'd0, 8'h55, 8'h55, 3'b000};
    tbl[15] = '{KIND_ALU,  MODE_EQ,  2'd0, 2'd1, 2'd2, 8'h00, 8'h01, 3'b000};
    tbl[16] = '{KIND_LOAD, MODE_ADD, 2'd1, 2'd0, 2'd0, 8'hAA, 8'hAA, 3'b000};
    tbl[17] = '{KIND_LOAD, MODE_ADD, 2'd2, 2'd0, 2'd0, 8'hAA, 8'hAA, 3'b000};
    tbl[18] = '{KIND_ALU,  MODE_XOR, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 3'b100};
    tbl[19] = '{KIND_LOAD, MODE_ADD, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h0F, 3'b100};
    tbl[20] = '{KIND_ALU,  MODE_NOT, 2'd2, 2'd1, 2'd0, 8'h00, 8'hF0, 3'b000};
    tbl[21] = '{KIND_READ, MODE_ADD, 2'd0, 2'd2, 2'd0, 8'h00, 8'hF0, 3'b000};
    tbl[22] = '{2'b11,     MODE_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h01, 3'b000};
    tbl[23] = '{KIND_ALU,  MODE_AND, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 3'b100};
    tbl[24] = '{KIND_ALU,  MODE_OR,  2'd0, 2'd1, 2'd2, 8'h00, 8'hFF, 3'b000};

    // Power-on reset: outputs must settle without any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", 32'(rsp_data), 32'd0);
    check("rst rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'd0);
    check("rst alu_mode", 32'(alu_mode), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      do_cmd(tbl[i].kind, tbl[i].mode, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
             1'b1, tbl[i].exp_d, tbl[i].exp_f, 0, $sformatf("tbl%0d", i));
    end

    // Reset asserted during EXEC of an ADD aborts it.
    do_cmd(KIND_LOAD, MODE_ADD, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0, 8'h00, 3'b000, 0, "pre_rst1");
    do_cmd(KIND_LOAD, MODE_ADD, 2'd2, 2'd0, 2'd0, 8'h03, 1'b0, 8'h00, 3'b000, 0, "pre_rst2");
    @(negedge clk);
    cmd_kind = KIND_ALU; cmd_mode = MODE_ADD; cmd_rd = 2'd3; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("midrst exec_a", 32'(alu_a), 32'h05);
    check("midrst exec_b", 32'(alu_b), 32'h03);
    #1 rst_n = 1'b0;
    #1;
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst alu_a", 32'(alu_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("midrst rsp_valid_after", 32'(rsp_valid), 32'd0);
    do_cmd(KIND_READ, MODE_ADD, 2'd0, 2'd3, 2'd0, 8'h00, 1'b1, 8'h00, 3'b000, 0, "midrst_rd3");
    do_cmd(KIND_READ, MODE_ADD, 2'd0, 2'd1, 2'd0, 8'h00, 1'b1, 8'h00, 3'b000, 0, "midrst_rd1");

    // Backpressure with cmd_valid held high; the second offer must not be taken.
    @(negedge clk);
    cmd_kind = KIND_LOAD; cmd_rd = 2'd0; cmd_imm = 8'h3C; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("bp rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_rd = 2'd1; cmd_imm = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_data", 32'(rsp_data), 32'h3C);
      check("bp rsp_flags", 32'(rsp_flags), 32'(flags_model));
      check("bp cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp rsp_valid_hold", 32'(rsp_valid), 32'd1);
    end
    $display("txn backpressure load r0=3c held 5 cycles data=%02h", rsp_data);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("bp cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("bp rsp_valid_after", 32'(rsp_valid), 32'd0);
    rf_model[0] = 8'h3C;
    do_cmd(KIND_READ, MODE_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h00, 3'b000, 0, "bp_rd0");
    do_cmd(KIND_READ, MODE_ADD, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h00, 3'b000, 0, "bp_rd1");

    // Random traffic against the reference model, with random response stalls.
    for (int n = 0; n < 150; n++) begin
      logic [1:0] k;
      k = ($urandom_range(0, 1) == 0) ? KIND_ALU : 2'($urandom_range(1, 3));
      do_cmd(k, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 8'($urandom), 1'b0, 8'h00, 3'b000,
             int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven operand sequencer that drives the combinational `alu` from the other side of its port list. It owns a small register file, and accepts commands over a valid/ready channel. For each ALU command it presents A, B and Mode to the ALU for one cycle, captures Results and flags into the destination register and a flag register, and returns the result over a valid/ready response channel. It sits between a test/control master and one `alu` instance.

## Interface
- `WIDTH`, default 8: datapath width; must match the connected `alu` instance.
- `NREG`, default 4: number of registers, power of two, ≥2; `RW = $clog2(NREG)`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_kind`  in  2  command kind: 00 ALU, 01 LOAD, 10 READ, 11 reserved (treated as READ).
- `cmd_mode`  in  3  ALU Mode for ALU commands (000 add … 111 equal).
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  RW each  destination and source register indices.
- `cmd_imm`  in  WIDTH  immediate for LOAD.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  master takes response.
- `rsp_data`  out  WIDTH  result, immediate or register value.
- `rsp_flags`  out  3  {zero, overflow, carry} at response time.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands.
- `alu_mode`  out  3  ALU Mode.
- `alu_result`  in  WIDTH  ALU Results.
- `alu_zero`, `alu_overflow`, `alu_carry`  in  1 each  ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- `cmd_ready` = (state == IDLE). A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
- Behaviour on acceptance, by command kind:
  - ALU: latch mode/rd/rs1/rs2, then go to EXEC.
  - LOAD: write `rf[rd] <= cmd_imm` and `rsp_data <= cmd_imm`, flags unchanged, then go to RESP.
  - READ: `rsp_data <= rf[rs1]`, flags unchanged, then go to RESP.
- EXEC, exactly one cycle:
  - Drive `alu_a = rf[rs1]`, `alu_b = rf[rs2]`, `alu_mode = mode`.
  - At the closing edge, write `rf[rd] <= alu_result` and `rsp_data <= alu_result`, then go to RESP.
- Flag update in EXEC, by mode:
  - Modes 000, 001: flags <= {alu_zero, alu_overflow, alu_carry}.
  - Modes 010–111: flags <= {(alu_result == 0), 0, 0}. The adder flags are meaningless for these modes.
- RESP: `rsp_valid = 1`. `rsp_data` and `rsp_flags` hold stable until the edge where `rsp_ready = 1`, then the FSM returns to IDLE.
- Outside EXEC, `alu_a`, `alu_b` and `alu_mode` are driven to 0.
- `rd` may equal `rs1` or `rs2`: operands are read in EXEC before the write edge.
- A later command sees all earlier writes (no forwarding needed, one command in flight).
- No pipelining: at most one command outstanding. `cmd_ready` stays low from acceptance until the response is consumed.

## Timing
- Reset (asynchronous, `rst_n` low): the FSM and every output take these values immediately, independent of `clk`:
  - FSM to IDLE.
  - All registers and flags cleared to 0.
  - `rsp_valid = 0`, `rsp_data = 0`, `rsp_flags = 0`.
  - `alu_a`, `alu_b`, `alu_mode` = 0.
  - `cmd_ready = 1`.
- Reset mid-operation aborts the command: no write-back, no response.
- ALU command latency: accepted at edge N, EXEC during cycle N..N+1, `rsp_valid` high after edge N+1, so 2 edges to response.
- LOAD/READ latency: `rsp_valid` high after the accept edge, so 1 edge.
- Response consumed at edge M, when `rsp_ready` is high in RESP. `cmd_ready` is high after edge M, so back-to-back commands run one every 3 cycles (ALU) or 2 cycles (LOAD/READ) with `rsp_ready` tied high.
- `rsp_ready` high while `rsp_valid` is low has no effect. `cmd_valid` while `cmd_ready` is low is ignored and must be held by the master.
- The ALU path is combinational within EXEC: alu_a/alu_b → alu_result must meet one clock period.

## Structure
- Shared package `alu_seq_pkg`:
  - Command-kind constants (KIND_ALU, KIND_LOAD, KIND_READ).
  - ALU mode constants (MODE_ADD … MODE_EQ).
  - FSM state enum.
  - Flag bit positions (FLAG_Z=2, FLAG_V=1, FLAG_C=0).
- Sub-module `alu_seq_regfile`: NREG×WIDTH, two combinational read ports, one synchronous write port, asynchronous active-low clear.
- The `alu` instance stays outside this block. The bench connects the two.

## Test plan
- Reset: after reset, READ r0…r3 → `rsp_data` = 0x00 each, `rsp_flags` = 000. Assert `rst_n` low during EXEC of an ADD → after release, `rsp_valid` = 0 and the destination register still reads 0.
- Add overflow: LOAD r1=0x7F, LOAD r2=0x01, ALU add r3=r1+r2 → `rsp_data` = 0x80, overflow = 1, zero = 0; READ r3 → 0x80.
- Subtract to zero and self-overwrite: ALU sub r2=r2−r2 with r2=0x01 → `rsp_data` = 0x00, zero = 1; READ r2 → 0x00.
- Signed compare and equal:
  - r1=0x80, r2=0x01, mode 110 → 0x01, flags zero = 0, V = 0, C = 0.
  - Mode 111 with r1 = r2 = 0x55 → 0x01.
- Logic-mode flags: XOR with r1 = r2 = 0xAA → `rsp_data` = 0x00, `rsp_flags` = 100. NOT of 0x0F → 0xF0, flags 000.
- Backpressure: hold `rsp_ready` low for 5 cycles after `rsp_valid`, with `cmd_valid` high throughout → `rsp_data`/`rsp_flags` stable, `cmd_ready` = 0, no second acceptance. Raise `rsp_ready` → `cmd_ready` high on the next cycle.
